lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store stage directly downstream of the ALU: takes alu_result as effective address (or passes it through).
//  Drives a single-outstanding valid/ready data-memory bus; forms byte masks/replicated store data.
//  Extracts and extends load data; returns one result per accepted op to writeback.
//  Multi-cycle FSM with backpressure on both sides and a response watchdog.
// PARAMETERS
//  TIMEOUT   255  max cycles in WAIT before forcing an error completion (1..255)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   async active-low reset
//  in_valid        in   1   op from EXU valid
//  in_ready        out  1   lsu_ctrl can accept op
//  alu_result      in   32  effective address / pass-through value
//  data_rs2        in   32  store data
//  mem_op          in   2   00 none(pass), 01 load, 10 store, 11 reserved(=error)
//  mem_size        in   2   00 byte, 01 half, 10 word, 11 illegal
//  IsSigned        in   1   load sign-extend (1) / zero-extend (0)
//  mem_req_valid   out  1   bus request valid
//  mem_req_ready   in   1   bus accepts request
//  mem_req_wen     out  1   1=store, 0=load
//  mem_req_addr    out  32  {addr[31:2],2'b00}
//  mem_req_wdata   out  32  replicated store data
//  mem_req_wmask   out  4   byte-lane write enables (0 for loads)
//  mem_resp_valid  in   1   response valid (load data or store ack)
//  mem_resp_rdata  in   32  aligned word read
//  mem_resp_err    in   1   bus error
//  out_valid       out  1   result to WBU valid
//  out_ready       in   1   WBU accepts result
//  out_data        out  32  load value / pass-through alu_result / faulting address
//  out_err         out  1   misaligned, illegal, bus error or timeout
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0 except in_ready=1, timeout counter 0; async assert, sync-deasserted upstream.
//  States IDLE, REQ, WAIT, DONE. in_ready = (state==IDLE). Inputs latched on in_valid&in_ready.
//  IDLE->DONE: mem_op=00 (out_data=alu_result, err=0), or misaligned/illegal (out_data=alu_result, err=1).
//   Misaligned: half & addr[0]; word & addr[1:0]!=0; size=11; op=11. No bus request issued.
//  IDLE->REQ otherwise. REQ: mem_req_valid=1, addr/wen/wdata/wmask stable; REQ->WAIT on mem_req_ready.
//  WAIT: resp sampled only here (resp in REQ cycle is ignored); on mem_resp_valid -> DONE,
//   out_err=mem_resp_err; counter++ each WAIT cycle; counter==TIMEOUT -> DONE, out_err=1, out_data=addr.
//   resp_valid and timeout in same cycle: response wins.
//  DONE: out_valid=1, out_data/out_err held; DONE->IDLE on out_ready. Counter cleared on leaving WAIT.
//  Latency: pass/misaligned out_valid 1 cycle after accept; memory ops >=3 cycles (REQ,WAIT,DONE).
//  Store: byte wmask=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}; half wmask=4'b0011<<a[1:0], wdata={2{rs2[15:0]}};
//   word wmask=4'hF, wdata=rs2. Store out_data=0.
//  Load: sh=rdata>>(8*a[1:0]); byte/half extended per IsSigned; word as-is.
//  Reset mid-op aborts; late response after reset ignored (state IDLE). One op outstanding max.
// TESTING
//  T1 pass: op=00, alu_result=0x1234_5678 -> out_valid next cycle, out_data=0x1234_5678, mem_req_valid never 1.
//  T2 lb/lbu: addr 0x8000_0003, rdata 0x80FF_0000 -> req_addr 0x8000_0000, wmask 0; signed 0xFFFF_FF80, unsigned 0x0000_0080.
//  T3 sh: addr 0x0000_0102, rs2 0xDEAD_BEEF -> wmask 4'b1100, wdata 0xBEEF_BEEF, wen=1; ack -> out_err=0.
//  T4 lw addr 0x0000_0002 -> out_err=1, out_data=0x0000_0002 next cycle, no bus request.
//  T5 load, no response -> out_valid with out_err=1 after TIMEOUT WAIT cycles; resp on last cycle -> err=0.
//  T6 mem_req_ready low 5 cyc, out_ready low 3 cyc -> outputs stable, in_ready=0; rst_n low in WAIT -> IDLE, late resp ignored.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store stage: turns an ALU effective address into a single-outstanding
// valid/ready memory transaction and returns one result per accepted op.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] data_rs2,
  input  logic [1:0]  mem_op,
  input  logic [1:0]  mem_size,
  input  logic        IsSigned,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q, rs2_q;
  logic [1:0]  op_q, size_q;
  logic        signed_q;
  logic [7:0]  wait_cnt;
  logic [31:0] out_data_q;
  logic        out_err_q;

  logic        accept;
  logic        bad_in;
  logic [31:0] shifted, load_val;
  logic        done_load;
  logic [31:0] done_data;
  logic        done_err;

  assign accept = in_valid & in_ready;

  // Misaligned or illegal encodings complete immediately without touching the bus.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bad_in = 1'b0;
    unique case (mem_size)
      2'b01:   bad_in = alu_result[0];
      2'b10:   bad_in = |alu_result[1:0];
      2'b11:   bad_in = 1'b1;
      default: bad_in = 1'b0;
    endcase
    if (mem_op == 2'b11) bad_in = 1'b1;
  end

  always_comb begin
    shifted  = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    load_val = shifted;
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    mem_req_wdata = rs2_q;
    mem_req_wmask = 4'hF;
    unique case (size_q)
      2'b00: begin
        mem_req_wdata = {4{rs2_q[7:0]}};
        mem_req_wmask = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        mem_req_wdata = {2{rs2_q[15:0]}};
        mem_req_wmask = 4'b0011 << addr_q[1:0];
      end
      default: ;
    endcase
    if (op_q != OP_STORE) mem_req_wmask = 4'h0;
  end

  assign mem_req_valid = (state == REQ);
  assign mem_req_wen   = (op_q == OP_STORE);
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_data      = out_data_q;
  assign out_err       = out_err_q;

  always_comb begin
    state_nxt = state;
    done_load = 1'b0;
    done_data = '0;
    done_err  = 1'b0;
    unique case (state)
      IDLE: if (in_valid) begin
        if (mem_op == OP_PASS || bad_in) begin
          state_nxt = DONE;
          done_load = 1'b1;
          done_data = alu_result;
          done_err  = (mem_op != OP_PASS);
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: if (mem_req_ready) state_nxt = WAIT;
      WAIT: begin
        // A response arriving in the final WAIT cycle beats the timeout.
        if (mem_resp_valid) begin
          state_nxt = DONE;
          done_load = 1'b1;
          done_err  = mem_resp_err;
          if (mem_resp_err)          done_data = addr_q;
          else if (op_q == OP_LOAD)  done_data = load_val;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = DONE;
          done_load = 1'b1;
          done_data = addr_q;
          done_err  = 1'b1;
        end
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rs2_q      <= '0;
      op_q       <= OP_PASS;
      size_q     <= '0;
      signed_q   <= 1'b0;
      wait_cnt   <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= alu_result;
        rs2_q    <= data_rs2;
        op_q     <= mem_op;
        size_q   <= mem_size;
        signed_q <= IsSigned;
      end
      if (state == WAIT && state_nxt == WAIT) wait_cnt <= wait_cnt + 8'd1;
      else                                    wait_cnt <= '0;
      if (done_load) begin
        out_data_q <= done_data;
        out_err_q  <= done_err;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: drives and samples on the falling edge,
// expected values are hand-computed constants.
module tb_lsu_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, data_rs2;
  logic [1:0]  mem_op, mem_size;
  logic        IsSigned;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .data_rs2(data_rs2),
    .mem_op(mem_op), .mem_size(mem_size), .IsSigned(IsSigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one op for a single cycle; returns on the falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic sgn);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_op = op; mem_size = size;
    alu_result = addr; data_rs2 = rs2; IsSigned = sgn;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called in REQ: stalls the request, then returns a response after extra WAIT cycles.
  task automatic do_mem(input int req_stall, input int resp_wait,
                        input logic [31:0] rdata, input logic err);
    logic [31:0] addr0;
    addr0 = mem_req_addr;
    for (int i = 0; i < req_stall; i++) begin
      @(negedge clk);
      check("req_hold_valid", 32'(mem_req_valid), 32'd1);
      check("req_hold_addr", mem_req_addr, addr0);
      check("req_hold_in_ready", 32'(in_ready), 32'd0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (resp_wait) @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata; mem_resp_err = err;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] data, input logic err);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, data);
    check({tag, "_err"}, 32'(out_err), 32'(err));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; data_rs2 = '0;
    mem_op = '0; mem_size = '0; IsSigned = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    mem_resp_err = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_wmask", 32'(mem_req_wmask), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 pass-through
    issue(2'b00, 2'b10, 32'h1234_5678, 32'h0, 1'b0);
    check("pass_no_req", 32'(mem_req_valid), 32'd0);
    expect_out("pass", 32'h1234_5678, 1'b0);

    // T2 lb / lbu
    issue(2'b01, 2'b00, 32'h8000_0003, 32'h0, 1'b1);
    check("lb_req_valid", 32'(mem_req_valid), 32'd1);
    check("lb_req_addr", mem_req_addr, 32'h8000_0000);
    check("lb_wmask", 32'(mem_req_wmask), 32'd0);
    check("lb_wen", 32'(mem_req_wen), 32'd0);
    do_mem(0, 0, 32'h80FF_0000, 1'b0);
    expect_out("lb", 32'hFFFF_FF80, 1'b0);
    issue(2'b01, 2'b00, 32'h8000_0003, 32'h0, 1'b0);
    do_mem(0, 2, 32'h80FF_0000, 1'b0);
    expect_out("lbu", 32'h0000_0080, 1'b0);

    // Half and word loads
    issue(2'b01, 2'b01, 32'h0000_0012, 32'h0, 1'b1);
    do_mem(0, 0, 32'hF00D_1234, 1'b0);
    expect_out("lh", 32'hFFFF_F00D, 1'b0);
    issue(2'b01, 2'b10, 32'h0000_0004, 32'h0, 1'b1);
    do_mem(0, 1, 32'h8765_4321, 1'b0);
    expect_out("lw", 32'h8765_4321, 1'b0);

    // T3 sh and other store sizes
    issue(2'b10, 2'b01, 32'h0000_0102, 32'hDEAD_BEEF, 1'b0);
    check("sh_addr", mem_req_addr, 32'h0000_0100);
    check("sh_wmask", 32'(mem_req_wmask), 32'hC);
    check("sh_wdata", mem_req_wdata, 32'hBEEF_BEEF);
    check("sh_wen", 32'(mem_req_wen), 32'd1);
    do_mem(0, 0, 32'h0, 1'b0);
    expect_out("sh", 32'h0, 1'b0);
    issue(2'b10, 2'b00, 32'h0000_0201, 32'h0000_00A5, 1'b0);
    check("sb_wmask", 32'(mem_req_wmask), 32'h2);
    check("sb_wdata", mem_req_wdata, 32'hA5A5_A5A5);
    do_mem(0, 0, 32'h0, 1'b0);
    expect_out("sb", 32'h0, 1'b0);

    // Bus error on a store reports the faulting address
    issue(2'b10, 2'b10, 32'h0000_0300, 32'h1122_3344, 1'b0);
    check("sw_wmask", 32'(mem_req_wmask), 32'hF);
    check("sw_wdata", mem_req_wdata, 32'h1122_3344);
    do_mem(0, 0, 32'h0, 1'b1);
    expect_out("sw_buserr", 32'h0000_0300, 1'b1);

    // T4 misaligned / illegal encodings
    issue(2'b01, 2'b10, 32'h0000_0002, 32'h0, 1'b0);
    check("lw_mis_no_req", 32'(mem_req_valid), 32'd0);
    expect_out("lw_mis", 32'h0000_0002, 1'b1);
    issue(2'b10, 2'b01, 32'h0000_0005, 32'h0, 1'b0);
    expect_out("sh_mis", 32'h0000_0005, 1'b1);
    issue(2'b01, 2'b11, 32'h0000_0008, 32'h0, 1'b0);
    expect_out("size_ill", 32'h0000_0008, 1'b1);
    issue(2'b11, 2'b10, 32'h0000_000C, 32'h0, 1'b0);
    check("op_ill_no_req", 32'(mem_req_valid), 32'd0);
    expect_out("op_ill", 32'h0000_000C, 1'b1);

    // T5 timeout: TO WAIT cycles with no response, then a response on the last one
    issue(2'b01, 2'b10, 32'h0000_0040, 32'h0, 1'b0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check("to_still_wait", 32'(out_valid), 32'd0);
    @(negedge clk);
    expect_out("timeout", 32'h0000_0040, 1'b1);
    issue(2'b01, 2'b10, 32'h0000_0044, 32'h0, 1'b0);
    do_mem(0, TO - 1, 32'hCAFE_F00D, 1'b0);
    expect_out("to_last_resp", 32'hCAFE_F00D, 1'b0);

    // T6 backpressure on both sides
    issue(2'b10, 2'b10, 32'h0000_0080, 32'h5555_AAAA, 1'b0);
    out_ready = 1'b0;
    do_mem(5, 0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    expect_out("bp", 32'h0, 1'b0);
    check("bp_idle", 32'(in_ready), 32'd1);

    // Reset while in WAIT, then a late response must be ignored
    issue(2'b01, 2'b10, 32'h0000_0090, 32'h0, 1'b0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_req", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("late_resp_out_valid", 32'(out_valid), 32'd0);
    check("late_resp_in_ready", 32'(in_ready), 32'd1);
    check("late_resp_out_data", out_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
